// File: rtl/ic_fill_ctrl_pkg.sv
// rtl/ic_fill_ctrl_pkg.sv - shared i-cache fill constants and state encoding
package ic_fill_ctrl_pkg;

   localparam int IC_LINE_W   = 256;
   localparam int IC_BUS_W    = 32;
   localparam int IC_BEATS    = IC_LINE_W / IC_BUS_W;
   localparam int IC_BEAT_W   = $clog2(IC_BEATS);
   localparam int IC_OFFSET_W = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_BURST = 3'd2,
      ST_DRAIN = 3'd3,
      ST_ACK   = 3'd4
   } ic_state_e;

endpackage

// File: rtl/ic_fill_ctrl_if.sv
// rtl/ic_fill_ctrl_if.sv - memory read bus between the fill engine and memory
interface ic_fill_ctrl_if;
   import ic_fill_ctrl_pkg::*;

   logic                bus_req;
   logic                bus_gnt;
   logic [31:0]         bus_addr;
   logic [IC_BUS_W-1:0] bus_rdata;
   logic                bus_rvalid;

   modport master (
      output bus_req,
      output bus_addr,
      input  bus_gnt,
      input  bus_rdata,
      input  bus_rvalid
   );

   modport slave (
      input  bus_req,
      input  bus_addr,
      output bus_gnt,
      output bus_rdata,
      output bus_rvalid
   );

endinterface

// File: rtl/ic_fill_ctrl_fill_line_buf.sv
// rtl/ic_fill_ctrl_fill_line_buf.sv - beat-addressed line register bank
module fill_line_buf #(
   parameter int BUS_W = 32,
   parameter int BEATS = 8,
   parameter int CNT_W = $clog2(BEATS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_i,
   input  logic [CNT_W-1:0]       beat_i,
   input  logic [BUS_W-1:0]       wdata_i,
   output logic [BEATS*BUS_W-1:0] line_o
);

   logic [BEATS-1:0] we;

   always_comb begin
      we         = '0;
      we[beat_i] = wr_i;
   end

   for (genvar g = 0; g < BEATS; g++) begin : g_word
      logic [BUS_W-1:0] word_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            word_q <= '0;
         end else if (we[g]) begin
            word_q <= wdata_i;
         end
      end

      assign line_o[g*BUS_W +: BUS_W] = word_q;
   end

endmodule

// File: rtl/ic_fill_ctrl.sv
// rtl/ic_fill_ctrl.sv - i-cache miss/fill engine: bus request, beat collection, fill ack
module ic_fill_ctrl
   import ic_fill_ctrl_pkg::*;
#(
   parameter int LINE_W = IC_LINE_W,
   parameter int BUS_W  = IC_BUS_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ic_miss,
   input  logic [31:0]           ic_miss_addr,
   input  logic                  ic_flush,
   ic_fill_ctrl_if.master        bus,
   output logic [LINE_W-1:0]     ic_fill_data,
   output logic                  ic_miss_ack,
   output logic                  busy
);

   localparam int BEATS = LINE_W / BUS_W;
   localparam int CNT_W = $clog2(BEATS);

   ic_state_e        state_q, state_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic             last_beat;
   logic             beat_wr;

   assign last_beat = bus.bus_rvalid && (beat_cnt_q == CNT_W'(BEATS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         beat_cnt_q <= '0;
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         addr_q     <= addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      addr_d     = addr_q;
      beat_wr    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ic_miss && !ic_flush) begin
               state_d    = ST_REQ;
               addr_d     = ic_miss_addr;
               beat_cnt_d = '0;
            end
         end
         ST_REQ: begin
            // Once granted the bus burst is owned and must be drained even if flushed.
            if (bus.bus_gnt) begin
               state_d = ic_flush ? ST_DRAIN : ST_BURST;
            end else if (ic_flush) begin
               state_d = ST_IDLE;
            end
         end
         ST_BURST: begin
            beat_wr = bus.bus_rvalid;
            if (bus.bus_rvalid) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
            if (last_beat) begin
               state_d = ic_flush ? ST_IDLE : ST_ACK;
            end else if (ic_flush) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            beat_wr = bus.bus_rvalid;
            if (bus.bus_rvalid) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
            if (last_beat) begin
               state_d = ST_IDLE;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.bus_req  = (state_q == ST_REQ) || (state_q == ST_BURST) || (state_q == ST_DRAIN);
   assign bus.bus_addr = addr_q;
   assign ic_miss_ack  = (state_q == ST_ACK);
   assign busy         = (state_q != ST_IDLE);

   fill_line_buf #(
      .BUS_W (BUS_W),
      .BEATS (BEATS),
      .CNT_W (CNT_W)
   ) u_line_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_i    (beat_wr),
      .beat_i  (beat_cnt_q),
      .wdata_i (bus.bus_rdata),
      .line_o  (ic_fill_data)
   );

endmodule
